proc_nios2_qsys_0_oci_dct_ctrl: RTL and testbench
=================================================

# proc_nios2_qsys_0_oci_dct_ctrl

Controller for the OCI direct compressed trace (DCT) datapath. Packs 2-bit trace atoms into a 30-bit DCT buffer with a 4-bit atom count, closes frames on full, on flush or at test end, and hands them to the trace store through a valid/ready handshake. It also runs the end-of-test drain sequence that produces `test_has_ended`.

## Interface
- No parameters; widths are fixed: buffer 30 bits = 15 atoms × 2 bits, count 4 bits.
- `clk` in 1: the single clock; every register is updated on the rising edge.
- `reset` in 1: synchronous, active-high.
- `atom_valid` in 1: an atom is presented this cycle.
- `atom` in 2: trace atom value.
- `flush_req` in 1: one-cycle pulse; close the partial frame.
- `test_ending` in 1: level or pulse; starts the drain sequence.
- `frame_valid` out 1: the output holding register holds a frame.
- `frame_ready` in 1: the trace store accepts the frame.
- `dct_buffer` out 30: frame atoms; atom k sits in bits [2k+1:2k], unused bits are 0.
- `dct_count` out 4: number of atoms in the frame, 1..15.
- `overflow` out 1: sticky flag, set when an atom is dropped.
- `test_has_ended` out 1: sticky flag, set when the drain is complete.
- `ovf_count` out 8: only present with the macro in Configuration.

## Operation
- Internal state:
  - accumulator `acc_buf[29:0]`, `acc_cnt[3:0]` (0..15);
  - output holding register driving `dct_buffer`/`dct_count`/`frame_valid`;
  - `flush_pend` bit;
  - FSM.
- `out_free` = !frame_valid | frame_ready. A transfer happens when frame_valid & frame_ready.
- `close_req` = (acc_cnt==15) | ((flush_req|flush_pend|state==DRAIN) & acc_cnt!=0).
- Close fires when close_req & out_free:
  - acc_buf/acc_cnt are copied to the holding register and frame_valid is set;
  - the accumulator is cleared;
  - flush_pend is cleared.
- If close_req & !out_free: set flush_pend when the close was flush-driven.
- If flush_req arrives with acc_cnt==0, it is a no-op and flush_pend stays 0.
- Atom accept in RUN:
  - If close fires this cycle, the atom goes to slot 0 of the new accumulator, so acc_cnt becomes 1.
  - Else if acc_cnt<15, the atom is written to slot acc_cnt and acc_cnt increments.
  - Else (acc_cnt==15 and no close) the atom is dropped and overflow is set.
- An atom arriving in the same cycle as flush_req belongs to the next frame.
- Transfer without a close this cycle clears frame_valid.
- FSM:
  - RUN → DRAIN on test_ending.
  - DRAIN: atoms are ignored; dropping them does not set overflow. Closes are forced.
  - DRAIN → DONE when acc_cnt==0 & !frame_valid.
  - DONE: test_has_ended=1; atoms are ignored. Only reset leaves DONE.
- test_ending while in DRAIN or DONE is ignored.

## Timing
- Reset values:
  - frame_valid=0, dct_buffer=0, dct_count=0;
  - overflow=0, test_has_ended=0, ovf_count=0;
  - acc cleared, flush_pend=0, state=RUN.
- Reset mid-frame discards the accumulator and the holding frame with no output.
- Latency:
  - The 15th atom, accepted at edge N, gives frame_valid=1 after edge N+1, assuming out_free holds at N+1.
  - flush_req at edge N, with out_free, gives frame_valid after edge N.
- Handshake:
  - dct_buffer and dct_count are stable while frame_valid & !frame_ready.
  - Back-to-back frames at full rate: transfer and close in the same cycle.
- Throughput: one atom per cycle is sustained when frame_ready=1.
- test_has_ended rises one cycle after the edge at which the last frame transfers. If the accumulator and holding register are both empty, it rises one cycle after test_ending is sampled.

## Configuration
- `PROC_NIOS2_OCI_DCT_OVF_CNT_EN` defined:
  - adds the `ovf_count` port;
  - the 8-bit counter increments once per dropped RUN-state atom and saturates at 255.
- Macro undefined: port and counter are absent; only the sticky overflow flag exists.

## Test plan
- Full frame:
  - Stimulus: reset, frame_ready=1, 15 atoms of value 2'b01 on consecutive cycles.
  - Response: one frame with dct_buffer=30'h15555555, dct_count=15; a 16th atom starts a new frame with count 1.
- Flush:
  - Stimulus: 3 atoms 3,2,1, then flush_req.
  - Response: dct_buffer=30'h1B, dct_count=3; an atom in the flush cycle appears as slot 0 of the next frame.
- Backpressure and overflow:
  - Stimulus: frame_ready=0, 32 atoms.
  - Response: first frame held stable with count 15; accumulator fills to 15; 2 atoms dropped; overflow=1; ovf_count=2 when the macro is defined.
- Drain:
  - Stimulus: 5 atoms, test_ending, frame_ready toggling.
  - Response: one frame with count 5; later atoms ignored with overflow unchanged; test_has_ended=1 one cycle after the transfer.
- Reset mid-operation:
  - Stimulus: 7 atoms, frame_valid pending, then reset.
  - Response: all outputs at reset values next cycle and no frame emitted.
- Simultaneous events:
  - Stimulus: transfer, 15-atom close and a new atom in the same cycle.
  - Response: new frame valid with no bubble, new accumulator count 1.

Source files
------------

// File: rtl/proc_nios2_qsys_0_oci_dct_ctrl_if.sv
// Atom input stream and frame output handshake of the OCI DCT controller.
// master = trace source / trace store side, slave = the controller.
interface proc_nios2_qsys_0_oci_dct_ctrl_if;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        flush_req;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  modport master (
    output atom_valid, atom, flush_req, frame_ready,
    input  frame_valid, dct_buffer, dct_count
  );

  modport slave (
    input  atom_valid, atom, flush_req, frame_ready,
    output frame_valid, dct_buffer, dct_count
  );
endinterface

// File: rtl/proc_nios2_qsys_0_oci_dct_ctrl.sv
// OCI DCT controller: packs 2-bit atoms into 15-atom frames, hands them out over
// valid/ready and runs the end-of-test drain. Optional macro: PROC_NIOS2_OCI_DCT_OVF_CNT_EN.
module proc_nios2_qsys_0_oci_dct_ctrl (
  input  logic                                   clk,
  input  logic                                   reset,
  proc_nios2_qsys_0_oci_dct_ctrl_if.slave        dct_if,
  input  logic                                   test_ending,
  output logic                                   overflow,
  output logic                                   test_has_ended
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
  ,
  output logic [7:0]                             ovf_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] acc_buf_q, acc_buf_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic [29:0] hold_buf_q, hold_buf_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        frame_valid_q, frame_valid_d;
  logic        flush_pend_q, flush_pend_d;
  logic        overflow_q, overflow_d;
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
  logic [7:0]  ovf_cnt_q, ovf_cnt_d;
`endif

  logic out_free;
  logic xfer;
  logic acc_empty;
  logic acc_full;
  logic flush_drv;
  logic close_req;
  logic close_fire;
  logic atom_in;
  logic atom_drop;

  always_comb begin
    out_free   = !frame_valid_q || dct_if.frame_ready;
    xfer       = frame_valid_q && dct_if.frame_ready;
    acc_empty  = (acc_cnt_q == 4'd0);
    acc_full   = (acc_cnt_q == 4'd15);
    flush_drv  = dct_if.flush_req || flush_pend_q || (state_q == ST_DRAIN);
    close_req  = acc_full || (flush_drv && !acc_empty);
    close_fire = close_req && out_free;
    atom_in    = dct_if.atom_valid && (state_q == ST_RUN);
    atom_drop  = atom_in && !close_fire && acc_full;
  end

  // Datapath next-state: frame close, handshake and atom packing.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    acc_buf_d     = acc_buf_q;
    acc_cnt_d     = acc_cnt_q;
    hold_buf_d    = hold_buf_q;
    hold_cnt_d    = hold_cnt_q;
    frame_valid_d = frame_valid_q;
    flush_pend_d  = flush_pend_q;
    overflow_d    = overflow_q;

    if (close_fire) begin
      hold_buf_d    = acc_buf_q;
      hold_cnt_d    = acc_cnt_q;
      frame_valid_d = 1'b1;
      acc_buf_d     = 30'd0;
      acc_cnt_d     = 4'd0;
      flush_pend_d  = 1'b0;
    end else begin
      if (xfer) frame_valid_d = 1'b0;
      // A blocked flush is remembered so the partial frame closes once the output frees up.
      if (dct_if.flush_req && !acc_empty) flush_pend_d = 1'b1;
    end

    if (atom_in) begin
      if (close_fire) begin
        acc_buf_d = {28'd0, dct_if.atom};
        acc_cnt_d = 4'd1;
      end else if (!acc_full) begin
        for (int k = 0; k < 15; k++) begin
          if (acc_cnt_q == 4'(k)) acc_buf_d[2*k +: 2] = dct_if.atom;
        end
        acc_cnt_d = acc_cnt_q + 4'd1;
      end
    end

    if (atom_drop) overflow_d = 1'b1;
  end

`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (atom_drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end
`endif

  // Drain FSM: DONE is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (test_ending) state_d = ST_DRAIN;
      ST_DRAIN: if (acc_empty && !frame_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      acc_buf_q     <= 30'd0;
      acc_cnt_q     <= 4'd0;
      // NOTE: the holding register is reset too, because dct_buffer/dct_count must read 0 out of reset.
      hold_buf_q    <= 30'd0;
      hold_cnt_q    <= 4'd0;
      frame_valid_q <= 1'b0;
      flush_pend_q  <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
      ovf_cnt_q     <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      acc_buf_q     <= acc_buf_d;
      acc_cnt_q     <= acc_cnt_d;
      hold_buf_q    <= hold_buf_d;
      hold_cnt_q    <= hold_cnt_d;
      frame_valid_q <= frame_valid_d;
      flush_pend_q  <= flush_pend_d;
      overflow_q    <= overflow_d;
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
      ovf_cnt_q     <= ovf_cnt_d;
`endif
    end
  end

  assign dct_if.frame_valid = frame_valid_q;
  assign dct_if.dct_buffer  = hold_buf_q;
  assign dct_if.dct_count   = hold_cnt_q;
  assign overflow           = overflow_q;
  assign test_has_ended     = (state_q == ST_DONE);
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
  assign ovf_count          = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_proc_nios2_qsys_0_oci_dct_ctrl.sv
// Scoreboard bench for the OCI DCT controller: expected frames are queued as
// stimulus is driven and compared whenever a frame transfers.
module tb_proc_nios2_qsys_0_oci_dct_ctrl;

  typedef struct {
    logic [29:0] data;
    logic [3:0]  cnt;
  } frame_t;

  logic clk;
  logic reset;
  logic test_ending;
  logic overflow;
  logic test_has_ended;
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  proc_nios2_qsys_0_oci_dct_ctrl_if dif ();

  proc_nios2_qsys_0_oci_dct_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .dct_if         (dif),
    .test_ending    (test_ending),
    .overflow       (overflow),
    .test_has_ended (test_has_ended)
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
    ,
    .ovf_count      (ovf_count)
`endif
  );

  frame_t sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  logic [1:0] at [0:31];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] pack(input int first, input int n);
    logic [29:0] d;
    d = 30'd0;
    for (int k = 0; k < n; k++) d[2*k +: 2] = at[first + k];
    return d;
  endfunction

  task automatic push(input logic [29:0] d, input logic [3:0] c);
    frame_t f;
    f.data = d;
    f.cnt  = c;
    sb.push_back(f);
  endtask

  // Inputs change 2 time units after a rising edge and are sampled at the next one.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_atom(input logic [1:0] a);
    dif.atom_valid = 1'b1;
    dif.atom       = a;
    step();
    dif.atom_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    dif.flush_req = 1'b1;
    step();
    dif.flush_req = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    dif.atom_valid  = 1'b0;
    dif.atom        = 2'd0;
    dif.flush_req   = 1'b0;
    dif.frame_ready = 1'b0;
    test_ending     = 1'b0;
    step();
    check("rst_valid", dif.frame_valid, 0);
    check("rst_buf", dif.dct_buffer, 0);
    check("rst_cnt", dif.dct_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ended", test_has_ended, 0);
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
    check("rst_ovf_count", ovf_count, 0);
`endif
    reset = 1'b0;
  endtask

  // Frame monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && dif.frame_valid && dif.frame_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", dif.dct_count, 0);
      end else begin
        frame_t e;
        e = sb.pop_front();
        check("frame_data", dif.dct_buffer, e.data);
        check("frame_cnt", dif.dct_count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] x;
    do_reset();

    // Full frame, then a 16th atom opens the next frame with count 1.
    dif.frame_ready = 1'b1;
    push(30'h15555555, 4'd15);
    for (int i = 0; i < 15; i++) send_atom(2'b01);
    check("full_lat_n", dif.frame_valid, 0);
    push(30'h2, 4'd1);
    send_atom(2'b10);
    check("full_lat_n1", dif.frame_valid, 1);
    check("full_cnt", dif.dct_count, 15);
    pulse_flush();
    wait_empty("full_drain");

    // Flush of a partial frame, with an atom in the flush cycle.
    do_reset();
    dif.frame_ready = 1'b1;
    send_atom(2'd3);
    send_atom(2'd2);
    send_atom(2'd1);
    push(30'h1B, 4'd3);
    push(30'h2, 4'd1);
    dif.atom_valid = 1'b1;
    dif.atom       = 2'b10;
    pulse_flush();
    dif.atom_valid = 1'b0;
    check("flush_lat", dif.frame_valid, 1);
    pulse_flush();
    wait_empty("flush_drain");
    pulse_flush();
    check("flush_empty_noop", dif.frame_valid, 0);

    // Backpressure, overflow, then transfer + full close + new atom in one cycle.
    do_reset();
    for (int i = 0; i < 32; i++) at[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 32; i++) begin
      send_atom(at[i]);
      if (i == 15) begin
        check("bp_valid", dif.frame_valid, 1);
        check("bp_buf", dif.dct_buffer, {2'b00, pack(0, 15)});
      end
      if (i == 29) check("bp_no_ovf_yet", overflow, 0);
    end
    check("bp_stable_buf", dif.dct_buffer, {2'b00, pack(0, 15)});
    check("bp_stable_cnt", dif.dct_count, 15);
    check("bp_ovf", overflow, 1);
`ifdef PROC_NIOS2_OCI_DCT_OVF_CNT_EN
    check("bp_ovf_count", ovf_count, 2);
`endif
    x = 2'($urandom_range(0, 3));
    push(pack(0, 15), 4'd15);
    push(pack(15, 15), 4'd15);
    push({28'd0, x}, 4'd1);
    dif.frame_ready = 1'b1;
    send_atom(x);
    check("sim_nobubble", dif.frame_valid, 1);
    check("sim_buf", dif.dct_buffer, {2'b00, pack(15, 15)});
    pulse_flush();
    wait_empty("sim_drain");

    // Drain with a partial frame and toggling ready.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      at[i] = 2'($urandom_range(0, 3));
      send_atom(at[i]);
    end
    push(pack(0, 5), 4'd5);
    test_ending = 1'b1;
    step();
    test_ending    = 1'b0;
    dif.atom_valid = 1'b1;
    dif.atom       = 2'd3;
    step();
    check("drain_close", dif.frame_valid, 1);
    step();
    dif.frame_ready = 1'b1;
    step();
    dif.frame_ready = 1'b0;
    check("drain_pre_end", test_has_ended, 0);
    step();
    check("drain_ended", test_has_ended, 1);
    check("drain_no_ovf", overflow, 0);
    dif.frame_ready = 1'b1;
    test_ending     = 1'b1;
    dif.flush_req   = 1'b1;
    for (int i = 0; i < 20; i++) step();
    dif.atom_valid  = 1'b0;
    test_ending     = 1'b0;
    dif.flush_req   = 1'b0;
    check("done_no_frame", dif.frame_valid, 0);
    check("done_sticky", test_has_ended, 1);
    check("done_ovf", overflow, 0);
    wait_empty("drain_sb");

    // Drain with nothing buffered.
    do_reset();
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    check("empty_drain_n", test_has_ended, 0);
    step();
    check("empty_drain_n1", test_has_ended, 1);

    // Reset with a held frame and a partial accumulator discards both.
    do_reset();
    for (int i = 0; i < 7; i++) send_atom(2'd2);
    pulse_flush();
    for (int i = 0; i < 3; i++) send_atom(2'd1);
    check("mid_pending", dif.frame_valid, 1);
    do_reset();
    dif.frame_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    pulse_flush();
    check("mid_acc_cleared", dif.frame_valid, 0);
    push(30'h3, 4'd1);
    send_atom(2'd3);
    pulse_flush();
    wait_empty("mid_drain");

    check("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
